// File: rtl/spisd_pkg.sv
// Shared definitions for the SD-card SPI path: byte-engine state encoding,
// divider width and the default SCLK half-period constants that the SD
// controller also uses when it picks its init and data rates.
package spisd_pkg;

  // Width of the SCLK half-period divider and of the HALF parameters.
  localparam int SPI_DIV_W = 8;

  // Default SCLK half-periods in clk cycles. Slow mode targets the ~400 kHz
  // card-identification rate; fast mode is the data-transfer rate.
  localparam int unsigned SPI_DIV_SLOW_DEFAULT = 63;
  localparam int unsigned SPI_DIV_FAST_DEFAULT = 2;

  typedef logic [SPI_DIV_W-1:0] spi_div_t;

  // Byte-engine states. LOW and HIGH are the two SCLK phases of one bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  // Selects the SCLK half-period for a transfer from the rate request.
  function automatic spi_div_t spi_half_sel(input logic     fast,
                                            input spi_div_t div_fast,
                                            input spi_div_t div_slow);
    return fast ? div_fast : div_slow;
  endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Loadable down-counter that times one SCLK phase. The engine loads HALF-1
// at the start of each phase; o_tick marks the last clk cycle of that phase.
module spi_halfperiod_timer
  import spisd_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_load,
  input  spi_div_t i_load_val,
  input  logic     i_en,
  output logic     o_tick
);

  spi_div_t r_count;

  // Count down towards zero while enabled; a load restarts the phase.
  always_ff @(posedge i_clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - spi_div_t'(1);
    end
  end

  // Phase expires when the counter has reached zero.
  assign o_tick = (r_count == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte engine for the SD-card path. Shifts one byte out on
// MOSI (MSB first) while sampling one byte from MISO, generates SCLK from clk
// at a slow or fast rate, and drives chip-select only between bytes.
module spi_byte_engine
  import spisd_pkg::*;
#(
  parameter int unsigned DIV_SLOW = SPI_DIV_SLOW_DEFAULT,
  parameter int unsigned DIV_FAST = SPI_DIV_FAST_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic       i_fast,
  input  logic       i_select,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_busy,
  output logic [7:0] o_out,
  output logic       o_readed
);

  localparam spi_div_t W_DIV_SLOW = spi_div_t'(DIV_SLOW);
  localparam spi_div_t W_DIV_FAST = spi_div_t'(DIV_FAST);

  spi_state_e r_state;
  spi_state_e w_next_state;

  // Datapath registers. TX keeps only the seven bits still to be sent, since
  // bit 7 goes straight to MOSI when the byte is accepted.
  logic [6:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  spi_div_t   r_half;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs_n;
  logic [7:0] r_out;

  // Control strobes decoded from state and divider tick.
  logic     w_accept;
  logic     w_rise;
  logic     w_fall_next;
  logic     w_fall_last;
  logic     w_busy;
  logic     w_readed;
  spi_div_t w_start_half;
  logic     w_div_tick;
  logic     w_div_load;
  spi_div_t w_div_load_val;
  logic     w_div_en;

  assign w_start_half = spi_half_sel(i_fast, W_DIV_FAST, W_DIV_SLOW);

  spi_halfperiod_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_div_load),
    .i_load_val (w_div_load_val),
    .i_en       (w_div_en),
    .o_tick     (w_div_tick)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: walk LOW/HIGH phases for eight bits, then one DONE cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (i_start)    w_next_state = ST_LOW;
      ST_LOW:  if (w_div_tick) w_next_state = ST_HIGH;
      ST_HIGH: if (w_div_tick) w_next_state = (r_bit_cnt == 3'd7) ? ST_DONE : ST_LOW;
      ST_DONE:                 w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    w_accept       = 1'b0;
    w_rise         = 1'b0;
    w_fall_next    = 1'b0;
    w_fall_last    = 1'b0;
    w_busy         = 1'b1;
    w_readed       = 1'b0;
    w_div_en       = 1'b0;
    w_div_load     = 1'b0;
    w_div_load_val = r_half - spi_div_t'(1);
    unique case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_accept = i_start;
        if (i_start) begin
          w_div_load     = 1'b1;
          w_div_load_val = w_start_half - spi_div_t'(1);
        end
      end
      ST_LOW: begin
        w_div_en   = 1'b1;
        w_rise     = w_div_tick;
        w_div_load = w_div_tick;
      end
      ST_HIGH: begin
        w_div_en    = 1'b1;
        w_fall_next = w_div_tick && (r_bit_cnt != 3'd7);
        w_fall_last = w_div_tick && (r_bit_cnt == 3'd7);
        w_div_load  = w_fall_next;
      end
      ST_DONE: begin
        w_readed = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Shift registers, SCLK/MOSI generation, result capture and chip-select.
  always_ff @(posedge i_clk) begin
    // NOTE: every register here has a defined reset value, so a reset in the
    // middle of a byte leaves no partial data and no stale result behind.
    if (i_rst) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_half     <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_out      <= '0;
    end else begin
      // CS follows the request only between bytes so it never moves mid-byte.
      if (r_state == ST_IDLE) begin
        r_cs_n <= ~i_select;
      end

      if (w_accept) begin
        r_tx_shift <= i_tx[6:0];
        r_rx_shift <= '0;
        r_half     <= w_start_half;
        r_bit_cnt  <= '0;
        r_mosi     <= i_tx[7];
        r_sclk     <= 1'b0;
      end

      // Rising SCLK: the card's bit has been stable for a full low phase.
      if (w_rise) begin
        r_sclk     <= 1'b1;
        r_rx_shift <= {r_rx_shift[6:0], i_miso};
      end

      // Falling SCLK mid-byte: present the next TX bit for the card.
      if (w_fall_next) begin
        r_sclk     <= 1'b0;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_mosi     <= r_tx_shift[6];
        r_tx_shift <= {r_tx_shift[5:0], 1'b1};
      end

      // Final falling edge: publish the byte so it is valid in the DONE cycle.
      if (w_fall_last) begin
        r_sclk <= 1'b0;
        r_mosi <= 1'b1;
        r_out  <= r_rx_shift;
      end
    end
  end

  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_cs_n   = r_cs_n;
  assign o_busy   = w_busy;
  assign o_out    = r_out;
  assign o_readed = w_readed;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: fast and slow transfers, ignored and
// back-to-back starts, chip-select timing, mid-byte reset and rate changes.
module tb_spi_byte_engine;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_tx;
  logic       i_fast;
  logic       i_select;
  logic       i_miso;
  logic       o_sclk;
  logic       o_mosi;
  logic       o_cs_n;
  logic       o_busy;
  logic [7:0] o_out;
  logic       o_readed;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int HALF_FAST = 2;
  localparam int HALF_SLOW = 63;

  spi_byte_engine #(
    .DIV_SLOW (HALF_SLOW),
    .DIV_FAST (HALF_FAST)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_tx     (i_tx),
    .i_fast   (i_fast),
    .i_select (i_select),
    .i_miso   (i_miso),
    .o_sclk   (o_sclk),
    .o_mosi   (o_mosi),
    .o_cs_n   (o_cs_n),
    .o_busy   (o_busy),
    .o_out    (o_out),
    .o_readed (o_readed)
  );

  always #5 i_clk = ~i_clk;

  // Runs one byte transfer from the current negedge. Cycle c is the interval
  // after rising edge c; start is sampled at edge 0. Expected SCLK/MOSI/busy/
  // readed come from the mode-0 timing: bit i owns cycles 1+2iH .. 2(i+1)H,
  // low for the first H of them. MISO is driven from pat on the same schedule.
  task automatic xfer(input logic [7:0] tx, input logic f, input logic [7:0] pat,
                      input int half, input bit poke_start, input bit toggle_fast,
                      input bit sel_at10);
    int   last;
    int   idx;
    logic e_sclk, e_mosi, e_busy, e_readed;
    last    = 16 * half;
    i_start = 1'b1;
    i_tx    = tx;
    i_fast  = f;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge i_clk);
      if (c <= last) begin
        idx    = (c - 1) / (2 * half);
        e_sclk = (((c - 1) % (2 * half)) >= half);
        e_mosi = tx[7 - idx];
      end else begin
        idx    = 7;
        e_sclk = 1'b0;
        e_mosi = 1'b1;
      end
      e_busy   = (c <= last + 1);
      e_readed = (c == last + 1);
      n_checks++;
      if (o_sclk !== e_sclk) begin
        n_fail++;
        $display("FAIL sclk tx=%h cycle %0d: got %b want %b", tx, c, o_sclk, e_sclk);
      end
      n_checks++;
      if (o_mosi !== e_mosi) begin
        n_fail++;
        $display("FAIL mosi tx=%h cycle %0d: got %b want %b", tx, c, o_mosi, e_mosi);
      end
      n_checks++;
      if (o_busy !== e_busy) begin
        n_fail++;
        $display("FAIL busy tx=%h cycle %0d: got %b want %b", tx, c, o_busy, e_busy);
      end
      n_checks++;
      if (o_readed !== e_readed) begin
        n_fail++;
        $display("FAIL readed tx=%h cycle %0d: got %b want %b", tx, c, o_readed, e_readed);
      end
      if (e_readed) begin
        n_checks++;
        if (o_out !== pat) begin
          n_fail++;
          $display("FAIL out tx=%h cycle %0d: got %h want %h", tx, c, o_out, pat);
        end
      end
      if (sel_at10 && (c <= last + 1)) begin
        n_checks++;
        if (o_cs_n !== 1'b1) begin
          n_fail++;
          $display("FAIL cs_n_hold cycle %0d: got %b want 1", c, o_cs_n);
        end
      end
      // Drive inputs for edge c; tx and (optionally) fast change mid-byte.
      i_tx    = ~tx;
      i_fast  = (toggle_fast && c >= 3) ? ~f : f;
      i_start = poke_start && ((c == 5) || (c == last + 1));
      i_miso  = (c <= last) ? pat[7 - idx] : 1'b0;
      if (sel_at10 && c == 10) i_select = 1'b1;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_sclk, o_mosi, o_cs_n, o_busy, o_readed} !== 5'b01100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got sclk/mosi/cs_n/busy/readed=%b want 01100",
               {o_sclk, o_mosi, o_cs_n, o_busy, o_readed});
    end
    n_checks++;
    if (o_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: got %h want 00", o_out);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_fast();
    xfer(8'hA5, 1'b1, 8'h3C, HALF_FAST, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL fast_out_hold: got %h want 3c", o_out);
    end
  endtask

  task automatic test_slow();
    xfer(8'hFF, 1'b0, 8'hFF, HALF_SLOW, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Starts at cycles 5 and 33 are ignored; the start at cycle 34 is taken.
    xfer(8'h5A, 1'b1, 8'hC3, HALF_FAST, 1'b1, 1'b0, 1'b0);
    xfer(8'h0F, 1'b1, 8'hF0, HALF_FAST, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_select();
    xfer(8'h81, 1'b1, 8'h7E, HALF_FAST, 1'b0, 1'b0, 1'b1);
    @(negedge i_clk);
    n_checks++;
    if (o_cs_n !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_n_after_xfer: got %b want 0", o_cs_n);
    end
    i_select = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL cs_n_deselect: got %b want 1", o_cs_n);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_readed;
    i_select = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_tx    = 8'hC3;
    i_fast  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_miso  = 1'b1;
      if (c == 12) i_rst = 1'b1;
    end
    @(negedge i_clk);
    n_checks++;
    if ({o_sclk, o_mosi, o_cs_n, o_busy, o_readed} !== 5'b01100) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got sclk/mosi/cs_n/busy/readed=%b want 01100",
               {o_sclk, o_mosi, o_cs_n, o_busy, o_readed});
    end
    n_checks++;
    if (o_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_out: got %h want 00", o_out);
    end
    i_rst      = 1'b0;
    saw_readed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_readed || o_busy) saw_readed = 1'b1;
    end
    n_checks++;
    if (saw_readed) begin
      n_fail++;
      $display("FAIL midreset_quiet: got readed/busy activity want none");
    end
    i_select = 1'b0;
    xfer(8'h3C, 1'b1, 8'hA5, HALF_FAST, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fast_toggle();
    xfer(8'h96, 1'b1, 8'h69, HALF_FAST, 1'b0, 1'b1, 1'b0);
    i_fast = 1'b0;
  endtask

  initial begin
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_tx     = 8'h00;
    i_fast   = 1'b0;
    i_select = 1'b0;
    i_miso   = 1'b0;
    test_reset();
    test_fast();
    test_slow();
    test_back_to_back();
    test_select();
    test_reset_mid();
    test_fast_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_engine.md
# spi_byte_engine

SPI mode-0 master byte engine for the SD-card path: shifts one byte out on MOSI while sampling one byte from MISO, generating SCLK from the system clock. It sits directly upstream of the SD receive buffer, and its `out`/`readed` outputs feed that buffer's `in`/`readed` inputs. It also drives chip-select and supports a slow (SD init, ≈400 kHz) and a fast SCLK rate.

## Interface
- `DIV_SLOW`, default 63, SCLK half-period in `clk` cycles for slow mode; legal range 1..255.
- `DIV_FAST`, default 2, SCLK half-period in `clk` cycles for fast mode; legal range 1..255.
- `clk`  in  1  system clock. One clock only; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request one byte transfer; accepted only when `busy`=0.
- `tx`  in  8  byte to transmit, latched on the accepted `start`.
- `fast`  in  1  rate select, latched on the accepted `start` (1 = `DIV_FAST`, 0 = `DIV_SLOW`).
- `select`  in  1  card-select request (1 = card selected).
- `miso`  in  1  serial data from card.
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  serial data to card, MSB first, idles high.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  transfer in progress.
- `out`  out  8  received byte; holds its value until the next transfer completes.
- `readed`  out  1  one-cycle strobe: `out` is valid this cycle.

## Operation
- State machine: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `sclk`=0, `mosi`=1, `busy`=0.
  - On `start`, latch `tx` into the shift register and HALF = `fast` ? `DIV_FAST` : `DIV_SLOW`.
  - Also clear the bit counter, load the divider with HALF-1, drive `mosi`=`tx[7]`, and go to LOW.
- LOW: `sclk`=0. When the divider reaches 0:
  - set `sclk`=1 and shift `miso` into the RX LSB (MSB first);
  - reload the divider and go to HIGH.
- HIGH: `sclk`=1. When the divider reaches 0:
  - set `sclk`=0;
  - if bit counter = 7, go to DONE;
  - otherwise bit counter +1, drive `mosi` with the next TX bit, reload the divider, and go to LOW.
- DONE (one cycle): `out` ← RX byte, `readed`=1, `mosi`=1, `busy`=1. Then go to IDLE.
- `busy`=1 in LOW, HIGH and DONE. `start` while `busy`=1 is ignored, with no queueing.
- Mid-transfer changes to `fast` or `tx` have no effect on the current byte.
- `cs_n` is registered as `~select`, but updates only in IDLE. A `select` change while `busy`=1 takes effect the first IDLE cycle after the transfer, so CS never toggles mid-byte.
- Divider is 8 bits; it counts down from HALF-1 to 0. Bit counter is 3 bits and never wraps inside a transfer.

## Timing
- Reset values (cycle after `rst`=1, from any state including mid-transfer):
  - state IDLE, `sclk`=0, `mosi`=1, `cs_n`=1, `busy`=0, `readed`=0, `out`=0x00, divider/counters 0;
  - a partial byte is discarded, with no `readed`.
- `start` sampled at edge 0:
  - `busy`=1 from cycle 1;
  - first `sclk` rising edge at cycle HALF+1;
  - `sclk` period = 2·HALF cycles.
- Last `sclk` falling edge at cycle 16·HALF+1, which is also the DONE cycle: `readed`=1 and `out` valid.
- `busy`=0 at cycle 16·HALF+2. The earliest accepted back-to-back `start` is sampled at that cycle, giving a throughput of one byte per 16·HALF+2 cycles.
- MISO is sampled on the `clk` edge that raises `sclk`. MOSI changes on the edge that lowers `sclk` (mode 0).
- `readed` is exactly one cycle wide and never asserts without a completed 8-bit transfer.

## Structure
- Shared package `spisd_pkg`:
  - state enum (IDLE/LOW/HIGH/DONE);
  - `SPI_DIV_W`=8;
  - default `DIV_SLOW`/`DIV_FAST` constants, shared with the SD controller.
- One natural sub-module: `spi_halfperiod_timer`, a loadable 8-bit down-counter with a `tick` output at 0. The FSM, shift registers and CS logic stay in `spi_byte_engine`.

## Test plan
- Fast mode (HALF=2), `tx`=0xA5, MISO model returns 0x3C:
  - MOSI at the 8 rising edges = 1,0,1,0,0,1,0,1;
  - `readed` pulse at cycle 33 with `out`=0x3C;
  - `busy`=0 at cycle 34.
- Slow mode, `DIV_SLOW`=63, `tx`=0xFF, MISO=1:
  - `sclk` high and low phases each exactly 63 cycles;
  - `out`=0xFF at cycle 1009;
  - `mosi` stays 1 throughout.
- `start` pulsed again at cycles 5 and 33 of a fast transfer: ignored, with exactly one `readed`. `start` at cycle 34: second transfer begins, `busy` from cycle 35.
- `select` 0→1 at cycle 10 of a transfer: `cs_n` stays 1 until the first IDLE cycle, then 0. `select` 1→0 in IDLE: `cs_n`=1 next cycle.
- `rst` asserted at cycle 12 of a transfer:
  - next cycle `sclk`=0, `mosi`=1, `cs_n`=1, `busy`=0, `out`=0x00;
  - no `readed`;
  - a new transfer after reset completes normally.
- `fast` toggled mid-transfer: the period stays at the latched rate until `readed`.
